irq_priority_sequencer: RTL

//  Sequential front end for the 27-channel (3 buses x 9 channels) interrupt priority resolver.
//  - Latches request pulses into pending registers and masks them with a per-channel enable.
//  - Resolves the highest-priority pending channel and presents it on a valid/ack grant handshake.
//  - Holds the grant in service until end-of-interrupt, then re-arbitrates.

---
 rtl/irq_seq_pkg.sv | 20 ++
 rtl/irq_prio_resolver.sv | 48 ++++
 rtl/irq_priority_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/irq_seq_pkg.sv
// rtl/irq_seq_pkg.sv - shared types and constants for the interrupt priority sequencer
package irq_seq_pkg;

    localparam int NUM_CH      = 9;
    localparam int NUM_BUS     = 3;
    localparam int CH_W        = 4;
    localparam int TIMEOUT_CYC = 255;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        GRANT   = 2'd2,
        SERVICE = 2'd3
    } state_t;

endpackage

// File: rtl/irq_prio_resolver.sv
// rtl/irq_prio_resolver.sv - combinational fixed-priority resolver over three eligible buses
module irq_prio_resolver
    import irq_seq_pkg::*;
#(
    parameter int NUM_CH = irq_seq_pkg::NUM_CH,
    parameter int CH_W   = irq_seq_pkg::CH_W
) (
    input  logic [NUM_CH-1:0] elig_a,
    input  logic [NUM_CH-1:0] elig_b,
    input  logic [NUM_CH-1:0] elig_c,
    output logic              any,
    output logic [1:0]        win_bus,
    output logic [CH_W-1:0]   win_ch
);

    logic [CH_W-1:0] ch_a;
    logic [CH_W-1:0] ch_b;
    logic [CH_W-1:0] ch_c;

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        ch_a = '0;
        ch_b = '0;
        ch_c = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (elig_a[i]) ch_a = CH_W'(i);
            if (elig_b[i]) ch_b = CH_W'(i);
            if (elig_c[i]) ch_c = CH_W'(i);
        end
    end

    always_comb begin
        any     = (|elig_a) | (|elig_b) | (|elig_c);
        win_bus = BUS_A;
        win_ch  = '0;
        if (|elig_a) begin
            win_bus = BUS_A;
            win_ch  = ch_a;
        end else if (|elig_b) begin
            win_bus = BUS_B;
            win_ch  = ch_b;
        end else if (|elig_c) begin
            win_bus = BUS_C;
            win_ch  = ch_c;
        end
    end

endmodule

// File: rtl/irq_priority_sequencer.sv
// rtl/irq_priority_sequencer.sv - pending latches, grant FSM and optional ack timeout (IRQ_SEQ_TIMEOUT_EN)
module irq_priority_sequencer
    import irq_seq_pkg::*;
#(
    parameter int NUM_CH      = irq_seq_pkg::NUM_CH,
    parameter int CH_W        = irq_seq_pkg::CH_W,
    parameter int TIMEOUT_CYC = irq_seq_pkg::TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_a,
    input  logic [NUM_CH-1:0] req_b,
    input  logic [NUM_CH-1:0] req_c,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              grant_valid,
    output logic [1:0]        grant_bus,
    output logic [CH_W-1:0]   grant_ch,
    input  logic              grant_ack,
    input  logic              eoi,
    output logic              busy,
    output logic              timeout_err
);

    state_t            state;
    state_t            next_state;
    logic [NUM_CH-1:0] pend_a;
    logic [NUM_CH-1:0] pend_b;
    logic [NUM_CH-1:0] pend_c;
    logic [NUM_CH-1:0] clr_a;
    logic [NUM_CH-1:0] clr_b;
    logic [NUM_CH-1:0] clr_c;
    logic [NUM_CH-1:0] ch_sel;
    logic              any_elig;
    logic [1:0]        win_bus;
    logic [CH_W-1:0]   win_ch;
    logic              ld_grant;
    logic              take_ack;
    logic              to_hit;

    irq_prio_resolver #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_resolver (
        .elig_a  (pend_a & ch_en),
        .elig_b  (pend_b & ch_en),
        .elig_c  (pend_c & ch_en),
        .any     (any_elig),
        .win_bus (win_bus),
        .win_ch  (win_ch)
    );

    assign grant_valid = (state == GRANT);
    assign busy        = (state != IDLE);
    assign ch_sel      = NUM_CH'(1) << grant_ch;

    always_comb begin
        next_state = state;
        ld_grant   = 1'b0;
        take_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig) next_state = ARB;
            end
            ARB: begin
                if (any_elig) begin
                    ld_grant   = 1'b1;
                    next_state = GRANT;
                end else begin
                    next_state = IDLE;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    take_ack   = 1'b1;
                    next_state = SERVICE;
                end else if (to_hit) begin
                    next_state = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        clr_a = '0;
        clr_b = '0;
        clr_c = '0;
        if (take_ack) begin
            case (grant_bus)
                BUS_A:   clr_a = ch_sel;
                BUS_B:   clr_b = ch_sel;
                BUS_C:   clr_c = ch_sel;
                default: ;
            endcase
        end
    end

    // A request arriving on the ack cycle re-sets the bit being cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend_a    <= '0;
            pend_b    <= '0;
            pend_c    <= '0;
            grant_bus <= BUS_A;
            grant_ch  <= '0;
        end else begin
            state  <= next_state;
            pend_a <= (pend_a & ~clr_a) | req_a;
            pend_b <= (pend_b & ~clr_b) | req_b;
            pend_c <= (pend_c & ~clr_c) | req_c;
            if (ld_grant) begin
                grant_bus <= win_bus;
                grant_ch  <= win_ch;
            end
        end
    end

`ifdef IRQ_SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

    logic [7:0] to_cnt;
    logic       to_err_q;

    assign to_hit      = (state == GRANT) && !grant_ack && (to_cnt == TIMEOUT_LIM - 8'd1);
    assign timeout_err = to_err_q;

    // Counter idles at zero outside GRANT, so every GRANT entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt   <= 8'd0;
            to_err_q <= 1'b0;
        end else begin
            to_err_q <= to_hit;
            if (state == GRANT) to_cnt <= to_cnt + 8'd1;
            else                to_cnt <= 8'd0;
        end
    end
`else
    logic [7:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 8'(TIMEOUT_CYC);
    assign to_hit             = 1'b0;
    assign timeout_err        = 1'b0;
`endif

endmodule
